pid_hit_buffer: RTL



---
 rtl/pid_hit_buffer_if.sv | 33 +++
 rtl/pid_hit_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pid_hit_buffer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pid_hit_buffer_if
// Description : Local-bus bundle between the readout master and the
//               per-channel hit buffer (address, write data, strobes, read data).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
interface pid_hit_buffer_if;
   logic [7:0]  Address;
   logic [31:0] DataIn;
   logic        Read;
   logic        Write;
   logic [31:0] DataOut;

   // Readout / slow-control side drives the access, receives read data
   modport master (
      output Address,
      output DataIn,
      output Read,
      output Write,
      input  DataOut
   );

   // Hit buffer side decodes the access, returns read data
   modport slave (
      input  Address,
      input  DataIn,
      input  Read,
      input  Write,
      output DataOut
   );
endinterface
`default_nettype wire

// File: rtl/pid_hit_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pid_hit_buffer
// Description : Stamps non-empty leading-edge patterns with a free-running
//               coarse counter, packs them with PID flags into 32-bit hit
//               words and queues them in a 16-deep FIFO drained over the
//               local bus. Tracks dropped words and exposes status/control.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module pid_hit_buffer #(
   parameter logic [7:0] BASE = 8'hE0
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic [31:0] Result,
   input  wire logic        Electron,
   input  wire logic        Muon,
   input  wire logic        Pion,
   pid_hit_buffer_if.slave  bus,
   output logic             Empty,
   output logic             Full
);

   localparam logic [7:0] c_ADDR_FIFO = BASE;
   localparam logic [7:0] c_ADDR_STAT = BASE + 8'd1;
   localparam logic [7:0] c_ADDR_CTRL = BASE + 8'd2;
   localparam logic [4:0] c_DEPTH     = 5'd16;

   // Timestamp and stage-1 pipeline
   logic [15:0] coarse_q;
   logic [31:0] r1_q;
   logic [15:0] stamp_q;
   logic        v1_q;

   // Control register
   logic        en_q;
   logic        pid_only_q;

   // Loss bookkeeping
   logic        lost_q, lost_d;
   logic [15:0] drops_q, drops_d;

   // FIFO state
   logic [31:0] mem_q [16];
   logic [3:0]  wr_ptr_q, wr_ptr_d;
   logic [3:0]  rd_ptr_q, rd_ptr_d;
   logic [4:0]  count_q, count_d;

   // Bus decode and FIFO handshake
   logic        rd_fifo, wr_stat, wr_ctrl;
   logic        flush, clr;
   logic        pop, push_req, accept, drop;

   // Hit word fields
   logic [4:0]  first_idx;
   logic [5:0]  popcnt;
   logic        found;
   logic [31:0] hit_word;

   // Only the two command bits of DataIn matter beyond CTRL
   logic        unused_din;
   assign unused_din = &{1'b0, bus.DataIn[31:2]};

   assign rd_fifo = bus.Read  && (bus.Address == c_ADDR_FIFO);
   assign wr_stat = bus.Write && (bus.Address == c_ADDR_STAT);
   assign wr_ctrl = bus.Write && (bus.Address == c_ADDR_CTRL);
   assign flush   = wr_stat && bus.DataIn[0];
   assign clr     = wr_stat && bus.DataIn[1];

   assign Empty   = (count_q == 5'd0);
   assign Full    = (count_q == c_DEPTH);

   // A read on an empty FIFO returns 0 and must not move the read pointer
   assign pop      = rd_fifo && !Empty;
   assign push_req = v1_q && !(pid_only_q && !(Electron || Muon || Pion));
   // A pop in the same clk frees the slot the push needs; flush discards the push
   assign accept   = push_req && !flush && (!Full || pop);
   assign drop     = push_req && !flush &&  Full && !pop;

   // Lowest set slice index and number of set slices of the stage-1 pattern
   always_comb begin
      first_idx = 5'd0;
      popcnt    = 6'd0;
      found     = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (r1_q[i] && !found) begin
            first_idx = 5'(i);
            found     = 1'b1;
         end
         popcnt = popcnt + 6'(r1_q[i]);
      end
   end

   assign hit_word = {stamp_q, first_idx, popcnt, Electron, Muon, Pion, lost_q, 1'b1};

   // Coarse counter and stage-1 capture of the pattern
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coarse_q <= 16'd0;
         r1_q     <= 32'd0;
         stamp_q  <= 16'd0;
         v1_q     <= 1'b0;
      end else begin
         coarse_q <= coarse_q + 16'd1;
         r1_q     <= Result;
         stamp_q  <= coarse_q;
         v1_q     <= (Result != 32'd0) && en_q;
      end
   end

   // Next-state for pointers, occupancy and loss tracking
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      lost_d   = lost_q;
      drops_d  = drops_q;

      if (flush) begin
         wr_ptr_d = 4'd0;
         rd_ptr_d = 4'd0;
         count_d  = 5'd0;
      end else begin
         wr_ptr_d = wr_ptr_q + 4'(accept);
         rd_ptr_d = rd_ptr_q + 4'(pop);
         count_d  = count_q + 5'(accept) - 5'(pop);
      end

      if (clr) begin
         lost_d  = 1'b0;
         drops_d = 16'd0;
      end else if (drop) begin
         lost_d  = 1'b1;
         if (drops_q != 16'hFFFF) begin
            drops_d = drops_q + 16'd1;
         end
      end else if (accept) begin
         // The accepted word already carries the pending loss flag
         lost_d  = 1'b0;
      end
   end

   // FIFO and loss state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 4'd0;
         rd_ptr_q <= 4'd0;
         count_q  <= 5'd0;
         lost_q   <= 1'b0;
         drops_q  <= 16'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         lost_q   <= lost_d;
         drops_q  <= drops_d;
      end
   end

   // Storage array; contents are meaningless until a pointer covers them
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= hit_word;
      end
   end

   // Control register writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q       <= 1'b1;
         pid_only_q <= 1'b0;
      end else if (wr_ctrl) begin
         en_q       <= bus.DataIn[0];
         pid_only_q <= bus.DataIn[1];
      end
   end

   // Read mux; zero when not addressed so several blocks can be OR-merged
   always_comb begin
      bus.DataOut = 32'd0;
      if (bus.Read) begin
         case (bus.Address)
            c_ADDR_FIFO: bus.DataOut = Empty ? 32'd0 : mem_q[rd_ptr_q];
            c_ADDR_STAT: bus.DataOut = {drops_q, 6'd0, Full, Empty, 3'd0, count_q};
            c_ADDR_CTRL: bus.DataOut = {30'd0, pid_only_q, en_q};
            default:     bus.DataOut = 32'd0;
         endcase
      end
   end

endmodule
`default_nettype wire
